dht22_sensor_emu: RTL and testbench
===================================

DHT22_SENSOR_EMU -- requirements
Module: dht22_sensor_emu

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter T_START_MIN_US, default 800, minimum host start-low time in microseconds that is accepted as a start request.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port dht22_in, input, 1 bit: the sampled open-drain bus level, pulled high externally.
REQ-006 SHALL have port dht22_drive_low, output, 1 bit: 1 = pull the bus low, 0 = release the bus.
REQ-007 SHALL have port humidity, input, 16 bits: RH x10, unsigned.
REQ-008 SHALL have port temperature, input, 16 bits: bit15 = sign, bits14:0 = |T| x10.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when END_LOW completes.
REQ-011 SHALL have port collision, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-012 SHALL pass dht22_in through a 2-flop synchronizer; all decisions use the synchronized level.
REQ-013 SHALL derive a 1 us tick from a counter of CLK_FREQ/1000000 cycles; all phase durations are counted in ticks.
REQ-014 SHALL implement these states: IDLE, HOST_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-015 IDLE -> HOST_LOW when the synchronized line is low; the low-duration counter restarts at this transition.
REQ-016 HOST_LOW -> RESP_DELAY on the line's rising edge if low time >= T_START_MIN_US; otherwise HOST_LOW -> IDLE silently.
REQ-017 The HOST_LOW low-time counter SHALL saturate rather than wrap.
REQ-018 On HOST_LOW -> RESP_DELAY the block SHALL snapshot humidity, temperature and parity into a 40-bit shift register; input changes during the frame have no effect.
REQ-019 Parity = (hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0]) mod 256.
REQ-020 Frame bit order: humidity, then temperature, then parity, MSB first.
REQ-021 Phase durations: RESP_DELAY 30 us released; RESP_LOW 80 us low; RESP_HIGH 80 us released; BIT_LOW 50 us low; BIT_HIGH 26 us released for a 0 bit, 70 us for a 1 bit; END_LOW 50 us low, then IDLE with the bus released.
REQ-022 After the 40th BIT_HIGH the block SHALL enter END_LOW; otherwise it returns to BIT_LOW and shifts the next bit.
REQ-023 dht22_drive_low SHALL be registered and asserted only in RESP_LOW, BIT_LOW and END_LOW.
REQ-024 Collision: if the synchronized line reads low during RESP_HIGH or BIT_HIGH, after 2 cycles of synchronizer settling, the block SHALL abort to IDLE, release the bus and pulse collision.
REQ-025 A new host start request is recognized only from IDLE; host activity in RESP_DELAY is ignored.

Reset
REQ-026 With rst sampled high, in the next cycle: state = IDLE, dht22_drive_low = 0, busy = 0, frame_done = 0, collision = 0, counters and shift register = 0.
REQ-027 Reset asserted mid-frame SHALL release the bus within one cycle, with no frame_done pulse.

Configuration
REQ-028 The macro DHT22_ERR_INJECT_EN SHALL control error injection.
REQ-029 When DHT22_ERR_INJECT_EN is defined, the block SHALL add input port err_inject (1 bit); if err_inject is high at snapshot, the transmitted parity byte is bitwise inverted.
REQ-030 When DHT22_ERR_INJECT_EN is undefined, port err_inject SHALL be absent and parity is always correct.

Structure
REQ-031 Package dht22_pkg SHALL hold the state enum, the phase-duration constants in us, FRAME_BITS = 40 and the parity function.
REQ-032 The sub-module dht22_us_tick (parameter CLK_FREQ, outputs a 1-cycle tick every us) SHALL be instantiated once.

Verification
REQ-033 Host low 1 ms then release, humidity = 0x028C, temperature = 0x8065 -> 40 bits decoded equal to 0x028C_8065_73, followed by one frame_done pulse.
REQ-034 At CLK_FREQ = 100 MHz -> RESP_LOW = 8000 cycles, bit-0 high = 2600 cycles, bit-1 high = 7000 cycles, each ±1 cycle.
REQ-035 Host low 500 us -> drive_low never asserts; busy returns to 0 after release.
REQ-036 Host forces the bus low 10 us into the 5th BIT_HIGH -> one collision pulse; IDLE; next valid start yields a complete frame.
REQ-037 rst pulsed during BIT_LOW -> drive_low = 0 next cycle; no frame_done.
REQ-038 With DHT22_ERR_INJECT_EN defined, err_inject = 1, humidity = 0x0000, temperature = 0x0000 -> transmitted parity = 0xFF.

Source files
------------

// File: rtl/dht22_pkg.sv
// Shared definitions for the DHT22 single-wire sensor emulator:
// FSM state type, phase durations in microseconds, frame length, parity helper.
package dht22_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOST_LOW,
      RESP_DELAY,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      END_LOW
   } dht22_state_e;

   localparam int unsigned FRAME_BITS = 40;

   localparam logic [15:0] T_RESP_DELAY_US = 16'd30;
   localparam logic [15:0] T_RESP_LOW_US   = 16'd80;
   localparam logic [15:0] T_RESP_HIGH_US  = 16'd80;
   localparam logic [15:0] T_BIT_LOW_US    = 16'd50;
   localparam logic [15:0] T_BIT0_HIGH_US  = 16'd26;
   localparam logic [15:0] T_BIT1_HIGH_US  = 16'd70;
   localparam logic [15:0] T_END_LOW_US    = 16'd50;

   // Checksum byte: byte-wise sum of humidity and temperature, modulo 256.
   function automatic logic [7:0] dht22_parity(input logic [15:0] hum, input logic [15:0] temp);
      return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
   endfunction

endpackage

// File: rtl/dht22_us_tick.sv
// Microsecond tick generator: one-cycle pulse every CLK_FREQ/1e6 clocks.
// clr restarts the prescaler so a phase always starts on a whole-microsecond boundary.
module dht22_us_tick #(
   parameter int unsigned CLK_FREQ = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned DIV   = (CLK_FREQ / 1000000 > 0) ? CLK_FREQ / 1000000 : 1;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next prescaler value: wrap at LAST or restart on clear.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tick is decoded from the register only, keeping clr out of any combinational loop.
   always_comb begin
      tick = (cnt_q == LAST);
   end

endmodule

// File: rtl/dht22_sensor_emu.sv
// DHT22 sensor emulator: answers a host start pulse on the open-drain bus
// with the response preamble and a 40-bit humidity/temperature/parity frame.
// Optional feature: define DHT22_ERR_INJECT_EN to add err_inject, which
// inverts the transmitted parity byte when high at snapshot time.
module dht22_sensor_emu
   import dht22_pkg::*;
#(
   parameter int unsigned CLK_FREQ       = 100000000,
   parameter int unsigned T_START_MIN_US = 800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dht22_in,
   output logic        dht22_drive_low,
   input  logic [15:0] humidity,
   input  logic [15:0] temperature,
`ifdef DHT22_ERR_INJECT_EN
   input  logic        err_inject,
`endif
   output logic        busy,
   output logic        frame_done,
   output logic        collision
);

   localparam logic [15:0] T_START_MIN = 16'(T_START_MIN_US);
   localparam logic [5:0]  LAST_BIT    = 6'(FRAME_BITS - 1);

   logic [1:0]   sync_q, sync_d;
   logic         line;
   logic         tick;
   logic         tick_clr;
   logic         inj;
   logic         phase_done;
   logic [15:0]  phase_len;
   logic         settled;

   dht22_state_e state_q, state_d;
   logic [15:0]  phase_cnt_q, phase_cnt_d;
   logic [1:0]   settle_q, settle_d;
   logic [5:0]   bit_idx_q, bit_idx_d;
   logic [39:0]  shift_q, shift_d;
   logic         drive_low_q, drive_low_d;
   logic         busy_q, busy_d;
   logic         frame_done_q, frame_done_d;
   logic         collision_q, collision_d;

   dht22_us_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (tick_clr),
      .tick (tick)
   );

`ifdef DHT22_ERR_INJECT_EN
   always_comb inj = err_inject;
`else
   always_comb inj = 1'b0;
`endif

   // Two-flop synchronizer; idles high like the pulled-up bus.
   always_comb begin
      sync_d = {sync_q[0], dht22_in};
      line   = sync_q[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   // Duration of the current timed phase in microsecond ticks.
   always_comb begin
      phase_len = '0;
      case (state_q)
         RESP_DELAY: phase_len = T_RESP_DELAY_US;
         RESP_LOW:   phase_len = T_RESP_LOW_US;
         RESP_HIGH:  phase_len = T_RESP_HIGH_US;
         BIT_LOW:    phase_len = T_BIT_LOW_US;
         BIT_HIGH:   phase_len = shift_q[39] ? T_BIT1_HIGH_US : T_BIT0_HIGH_US;
         END_LOW:    phase_len = T_END_LOW_US;
         default:    phase_len = '0;
      endcase
   end

   // Next-state, counter, shift and pulse logic.
   // settle_q counts cycles since phase entry: the synchronized line lags our
   // own release by two cycles, so the line is only trusted once settle_q == 2.
   always_comb begin
      state_d      = state_q;
      phase_cnt_d  = phase_cnt_q;
      settle_d     = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      frame_done_d = 1'b0;
      collision_d  = 1'b0;
      settled      = (settle_q == 2'd2);
      phase_done   = tick && (phase_cnt_q == phase_len - 16'd1);

      if (tick && (phase_cnt_q != '1)) begin
         phase_cnt_d = phase_cnt_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (settled && !line) begin
               state_d = HOST_LOW;
            end
         end
         HOST_LOW: begin
            if (line) begin
               if (phase_cnt_q >= T_START_MIN) begin
                  state_d = RESP_DELAY;
                  shift_d = {humidity, temperature,
                             dht22_parity(humidity, temperature) ^ {8{inj}}};
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RESP_DELAY: begin
            if (phase_done) state_d = RESP_LOW;
         end
         RESP_LOW: begin
            if (phase_done) state_d = RESP_HIGH;
         end
         RESP_HIGH: begin
            if (settled && !line) begin
               state_d     = IDLE;
               collision_d = 1'b1;
            end else if (phase_done) begin
               state_d   = BIT_LOW;
               bit_idx_d = '0;
            end
         end
         BIT_LOW: begin
            if (phase_done) state_d = BIT_HIGH;
         end
         BIT_HIGH: begin
            if (settled && !line) begin
               state_d     = IDLE;
               collision_d = 1'b1;
            end else if (phase_done) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d = END_LOW;
               end else begin
                  state_d   = BIT_LOW;
                  bit_idx_d = bit_idx_q + 6'd1;
                  shift_d   = {shift_q[38:0], 1'b0};
               end
            end
         end
         END_LOW: begin
            if (phase_done) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      tick_clr = (state_d != state_q);
      if (tick_clr) begin
         phase_cnt_d = '0;
         settle_d    = '0;
      end

      drive_low_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
      busy_d      = (state_d != IDLE);
   end

   // FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         phase_cnt_q  <= '0;
         settle_q     <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         drive_low_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         collision_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_cnt_q  <= phase_cnt_d;
         settle_q     <= settle_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         drive_low_q  <= drive_low_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         collision_q  <= collision_d;
      end
   end

   always_comb begin
      dht22_drive_low = drive_low_q;
      busy            = busy_q;
      frame_done      = frame_done_q;
      collision       = collision_q;
   end

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Self-checking bench for dht22_sensor_emu. The DUT runs at 2 MHz so a full
// frame stays short; expected phase lengths scale as microseconds * DIV.
module tb_dht22_sensor_emu;

   localparam int unsigned CLK_HZ = 2000000;
   localparam int DIV = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_low = 1'b0;
   logic        dht22_in;
   logic        drive;
   logic [15:0] hum = '0;
   logic [15:0] temp = '0;
   logic        busy;
   logic        frame_done;
   logic        collision;
`ifdef DHT22_ERR_INJECT_EN
   logic        err_inject = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int fd_cnt = 0;
   int col_cnt = 0;
   int drive_cyc = 0;

   always #5 clk = ~clk;

   // Open-drain bus with external pull-up.
   assign dht22_in = ~(drive | host_low);

   dht22_sensor_emu #(.CLK_FREQ(CLK_HZ), .T_START_MIN_US(800)) dut (
      .clk             (clk),
      .rst             (rst),
      .dht22_in        (dht22_in),
      .dht22_drive_low (drive),
      .humidity        (hum),
      .temperature     (temp),
`ifdef DHT22_ERR_INJECT_EN
      .err_inject      (err_inject),
`endif
      .busy            (busy),
      .frame_done      (frame_done),
      .collision       (collision)
   );

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (collision === 1'b1) col_cnt++;
      if (drive === 1'b1) drive_cyc++;
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: run still active after 120000 cycles, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int near(input int got, input int want);
      return (got >= want - 1 && got <= want + 1) ? want : got;
   endfunction

   // Reference frame straight from the sensor protocol definition.
   function automatic logic [39:0] model(input logic [15:0] h, input logic [15:0] t, input bit inj);
      int p;
      logic [7:0] pb;
      p  = (int'(h) / 256) + (int'(h) % 256) + (int'(t) / 256) + (int'(t) % 256);
      p  = p % 256;
      if (inj) p = 255 - p;
      pb = 8'(p);
      return {h, t, pb};
   endfunction

   task automatic count_level(input logic lvl, input int budget, output int n);
      n = 0;
      while (drive === lvl && n < budget) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_drive(input logic lvl, input int budget, output bit ok);
      int n;
      n = 0;
      while (drive !== lvl && n < budget) begin
         n++;
         @(negedge clk);
      end
      ok = (drive === lvl);
   endtask

   task automatic host_pulse(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us * DIV) @(negedge clk);
      host_low = 1'b0;
   endtask

   // Decode one frame from the DUT drive pattern; optionally collide in bit collide_bit.
   task automatic rx_frame(input logic [39:0] exp_frame, input string tag, input int collide_bit);
      int n;
      int fd0;
      int c0;
      int low_err;
      int hi_err;
      int want;
      bit ok;
      logic [39:0] got;
      fd0 = fd_cnt;
      low_err = 0;
      hi_err = 0;
      got = '0;
      wait_drive(1'b1, 200 * DIV, ok);
      check({tag, " resp_start"}, 64'(ok), 64'(1));
      if (!ok) return;
      hum  = 16'($urandom);
      temp = 16'($urandom);
      count_level(1'b1, 400 * DIV, n);
      check({tag, " resp_low_len"}, 64'(near(n, 80 * DIV)), 64'(80 * DIV));
      count_level(1'b0, 400 * DIV, n);
      check({tag, " resp_high_len"}, 64'(near(n, 80 * DIV)), 64'(80 * DIV));
      for (int i = 0; i < 40; i++) begin
         count_level(1'b1, 400 * DIV, n);
         if (near(n, 50 * DIV) != 50 * DIV) low_err++;
         if (i == collide_bit) begin
            c0 = col_cnt;
            repeat (10 * DIV) @(negedge clk);
            host_low = 1'b1;
            n = 0;
            while (collision !== 1'b1 && n < 20) begin
               n++;
               @(negedge clk);
            end
            host_low = 1'b0;
            repeat (10) @(negedge clk);
            check({tag, " collision_pulses"}, 64'(col_cnt - c0), 64'(1));
            check({tag, " busy_after_collision"}, 64'(busy), 64'(0));
            check({tag, " drive_after_collision"}, 64'(drive), 64'(0));
            check({tag, " no_frame_done"}, 64'(fd_cnt - fd0), 64'(0));
            return;
         end
         count_level(1'b0, 400 * DIV, n);
         got  = {got[38:0], (n > 48 * DIV)};
         want = exp_frame[39 - i] ? 70 * DIV : 26 * DIV;
         if (near(n, want) != want) hi_err++;
      end
      count_level(1'b1, 400 * DIV, n);
      check({tag, " end_low_len"}, 64'(near(n, 50 * DIV)), 64'(50 * DIV));
      check({tag, " bit_low_errs"}, 64'(low_err), 64'(0));
      check({tag, " bit_high_errs"}, 64'(hi_err), 64'(0));
      check({tag, " frame_data"}, 64'(got), 64'(exp_frame));
      repeat (4) @(negedge clk);
      check({tag, " frame_done_pulses"}, 64'(fd_cnt - fd0), 64'(1));
      check({tag, " busy_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      logic [39:0] exp_f;
      int n;
      int fd0;
      int d0;
      bit ok;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset drive_low", 64'(drive), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      check("reset frame_done", 64'(frame_done), 64'(0));
      check("reset collision", 64'(collision), 64'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Directed frame from the reference example
      hum = 16'h028C;
      temp = 16'h8065;
      exp_f = model(hum, temp, 1'b0);
      check("model example", 64'(exp_f), 64'(40'h028C806573));
      host_pulse(1000);
      rx_frame(exp_f, "directed", -1);

      // Random frames; inputs change mid-frame and must not affect the snapshot
      for (int k = 0; k < 2; k++) begin
         repeat (20) @(negedge clk);
         hum = 16'($urandom);
         temp = 16'($urandom);
         exp_f = model(hum, temp, 1'b0);
         host_pulse(900 + int'($urandom_range(0, 100)));
         rx_frame(exp_f, "random", -1);
      end

      // Collision in the 5th bit-high phase, then a clean frame
      repeat (20) @(negedge clk);
      hum = 16'($urandom);
      temp = 16'($urandom);
      exp_f = model(hum, temp, 1'b0);
      host_pulse(1000);
      rx_frame(exp_f, "collide", 4);
      repeat (20) @(negedge clk);
      hum = 16'($urandom);
      temp = 16'($urandom);
      exp_f = model(hum, temp, 1'b0);
      host_pulse(1000);
      rx_frame(exp_f, "after_collide", -1);

      // Reset during BIT_LOW of the third bit
      repeat (20) @(negedge clk);
      fd0 = fd_cnt;
      host_pulse(1000);
      wait_drive(1'b1, 200 * DIV, ok);
      check("rst_test resp_start", 64'(ok), 64'(1));
      count_level(1'b1, 400 * DIV, n);
      count_level(1'b0, 400 * DIV, n);
      for (int i = 0; i < 2; i++) begin
         count_level(1'b1, 400 * DIV, n);
         count_level(1'b0, 400 * DIV, n);
      end
      check("rst_test in_bit_low", 64'(drive), 64'(1));
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_test drive_released", 64'(drive), 64'(0));
      check("rst_test busy", 64'(busy), 64'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      d0 = drive_cyc;
      repeat (300 * DIV) @(negedge clk);
      check("rst_test no_frame_done", 64'(fd_cnt - fd0), 64'(0));
      check("rst_test no_drive", 64'(drive_cyc - d0), 64'(0));

      // Short 500 us host pulse is rejected
      d0 = drive_cyc;
      @(negedge clk);
      host_low = 1'b1;
      repeat (250 * DIV) @(negedge clk);
      check("short busy_during_low", 64'(busy), 64'(1));
      repeat (250 * DIV) @(negedge clk);
      host_low = 1'b0;
      repeat (20) @(negedge clk);
      check("short busy_after", 64'(busy), 64'(0));
      repeat (200 * DIV) @(negedge clk);
      check("short no_drive", 64'(drive_cyc - d0), 64'(0));

`ifdef DHT22_ERR_INJECT_EN
      // Injected parity error on all-zero data
      err_inject = 1'b1;
      hum = '0;
      temp = '0;
      exp_f = model(hum, temp, 1'b1);
      check("err model", 64'(exp_f), 64'(40'h00000000FF));
      host_pulse(1000);
      rx_frame(exp_f, "err_inject", -1);
      err_inject = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
